// File: rtl/instr_fetch.sv
// Instruction fetch/sequencing stage: runs the 8-phase machine cycle, drives the PC
// onto the ROM bus, assembles one/two-byte instructions and owns the PC and 3-level stack.
module instr_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  data_in,
   input  logic        pc_load,
   input  logic [11:0] pc_value,
   input  logic        stack_push,
   input  logic        stack_pop,
   output logic [3:0]  data_out,
   output logic        bus_drive,
   output logic        sync,
   output logic [2:0]  phase,
   output logic [3:0]  command,
   output logic [3:0]  immediate,
   output logic [7:0]  operand,
   output logic        two_byte,
   output logic        instr_valid,
   output logic [11:0] pc
);
   typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

   phase_t      phase_reg, phase_next;
   logic [11:0] pc_reg;
   logic [1:0]  sp_reg, sp_inc, sp_dec;
   logic [11:0] stack_reg [0:2];
   logic [3:0]  opr_reg, command_reg, immediate_reg;
   logic [7:0]  operand_reg;
   logic        two_byte_reg, instr_valid_reg, second_reg, exec_reg;
   logic        is_two, ctrl_en, do_pop, do_push, do_load;

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_reg <= A1;
      end else begin
         phase_reg <= phase_next;
      end
   end

   always_comb begin
      phase_next = phase_t'(phase_reg + 3'd1);
      data_out   = 4'd0;
      bus_drive  = 1'b0;
      sync       = 1'b0;
      case (phase_reg)
         A1: begin
            data_out  = pc_reg[3:0];
            bus_drive = 1'b1;
            sync      = 1'b1;
         end
         A2: begin
            data_out  = pc_reg[7:4];
            bus_drive = 1'b1;
         end
         A3: begin
            data_out  = pc_reg[11:8];
            bus_drive = 1'b1;
         end
         default: ;
      endcase
   end

   // OPA is taken straight off the bus at the M2 edge so the decode is visible during X1.
   always_comb begin
      is_two = 1'b0;
      case (opr_reg)
         4'h1, 4'h4, 4'h5, 4'h7: is_two = 1'b1;
         4'h2:                   is_two = ~data_in[0];
         default:                is_two = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         opr_reg         <= 4'd0;
         command_reg     <= 4'd0;
         immediate_reg   <= 4'd0;
         operand_reg     <= 8'd0;
         two_byte_reg    <= 1'b0;
         instr_valid_reg <= 1'b0;
         second_reg      <= 1'b0;
         exec_reg        <= 1'b0;
      end else begin
         instr_valid_reg <= 1'b0;
         if (phase_reg == M1) begin
            opr_reg <= data_in;
         end
         if (phase_reg == M2) begin
            if (second_reg) begin
               operand_reg     <= {opr_reg, data_in};
               second_reg      <= 1'b0;
               instr_valid_reg <= 1'b1;
               exec_reg        <= 1'b1;
            end else begin
               command_reg     <= opr_reg;
               immediate_reg   <= data_in;
               two_byte_reg    <= is_two;
               second_reg      <= is_two;
               instr_valid_reg <= ~is_two;
               exec_reg        <= ~is_two;
            end
         end
      end
   end

   // Execute-side requests count only in X3 of a cycle that completed an instruction.
   assign ctrl_en = (phase_reg == X3) && exec_reg;
   assign do_pop  = ctrl_en && stack_pop;
   assign do_push = ctrl_en && !stack_pop && stack_push;
   assign do_load = ctrl_en && !stack_pop && !stack_push && pc_load;

   assign sp_inc = (sp_reg == 2'd2) ? 2'd0 : sp_reg + 2'd1;
   assign sp_dec = (sp_reg == 2'd0) ? 2'd2 : sp_reg - 2'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_reg <= 12'd0;
         sp_reg <= 2'd0;
         for (int i = 0; i < 3; i++) begin
            stack_reg[i] <= 12'd0;
         end
      end else begin
         if (phase_reg == M2) begin
            pc_reg <= pc_reg + 12'd1;
         end else if (do_pop) begin
            pc_reg <= stack_reg[sp_dec];
            sp_reg <= sp_dec;
         end else if (do_push) begin
            stack_reg[sp_reg] <= pc_reg;
            sp_reg            <= sp_inc;
            pc_reg            <= pc_value;
         end else if (do_load) begin
            pc_reg <= pc_value;
         end
      end
   end

   assign phase       = phase_reg;
   assign command     = command_reg;
   assign immediate   = immediate_reg;
   assign operand     = operand_reg;
   assign two_byte    = two_byte_reg;
   assign instr_valid = instr_valid_reg;
   assign pc          = pc_reg;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a ROM/execute model reacts to the bus, expected
// instructions are queued per program and checked by a monitor on each instr_valid.
module tb_instr_fetch;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  data_in;
   logic        pc_load;
   logic [11:0] pc_value;
   logic        stack_push;
   logic        stack_pop;
   logic [3:0]  data_out;
   logic        bus_drive;
   logic        sync;
   logic [2:0]  phase;
   logic [3:0]  command;
   logic [3:0]  immediate;
   logic [7:0]  operand;
   logic        two_byte;
   logic        instr_valid;
   logic [11:0] pc;

   always #5 clk = ~clk;

   instr_fetch dut (
      .clk(clk), .reset(reset), .data_in(data_in), .pc_load(pc_load),
      .pc_value(pc_value), .stack_push(stack_push), .stack_pop(stack_pop),
      .data_out(data_out), .bus_drive(bus_drive), .sync(sync), .phase(phase),
      .command(command), .immediate(immediate), .operand(operand),
      .two_byte(two_byte), .instr_valid(instr_valid), .pc(pc)
   );

   typedef struct packed {
      logic [3:0]  cmd;
      logic [3:0]  imm;
      logic [7:0]  opd;
      logic        two;
      logic [11:0] pc;
   } exp_t;

   exp_t        exp_q[$];
   logic [11:0] addr_q[$];
   logic [1:0]  sp_hist[$];
   logic [1:0]  sp_last;
   logic        sp_rec = 1'b0;
   logic [7:0]  rom [0:4095];
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [3:0] c, input logic [3:0] i, input logic [7:0] o,
                           input logic t, input logic [11:0] p);
      exp_t e;
      e.cmd = c; e.imm = i; e.opd = o; e.two = t; e.pc = p;
      exp_q.push_back(e);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
   endtask

   task automatic wait_empty(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) break;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL timeout: %0d instructions outstanding, required 0", exp_q.size());
      end
   endtask

   // ROM bus, phase model and execute-side control model
   initial begin
      logic [11:0] addr;
      logic [2:0]  ph;
      logic        rs;
      addr = 12'd0;
      ph = 3'd0;
      data_in = 4'd0;
      pc_load = 1'b0; pc_value = 12'd0; stack_push = 1'b0; stack_pop = 1'b0;
      forever begin
         @(posedge clk);
         rs = reset;
         @(negedge clk);
         ph = rs ? 3'd0 : ph + 3'd1;
         chk("phase", 32'(phase), 32'(ph));
         chk("sync", 32'(sync), 32'(ph == 3'd0));
         chk("bus_drive", 32'(bus_drive), 32'(ph < 3'd3));
         case (ph)
            3'd0: addr[3:0]  = data_out;
            3'd1: addr[7:4]  = data_out;
            3'd2: addr[11:8] = data_out;
            default: ;
         endcase
         if (ph == 3'd3 && addr_q.size() > 0) begin
            logic [11:0] a;
            a = addr_q.pop_front();
            chk("fetch_addr", 32'(addr), 32'(a));
         end
         if (ph == 3'd3)      data_in = rom[addr][7:4];
         else if (ph == 3'd4) data_in = rom[addr][3:0];
         else                 data_in = 4'd0;
         if (ph == 3'd5) begin
            pc_load = 1'b0; stack_push = 1'b0; stack_pop = 1'b0;
            pc_value = {immediate, operand};
            if (instr_valid) begin
               case (command)
                  4'h4: pc_load = 1'b1;
                  4'h5: stack_push = 1'b1;
                  4'hC: stack_pop = 1'b1;
                  default: ;
               endcase
            end else begin
               // requests during a non-completing cycle must be ignored
               pc_load = 1'b1; stack_pop = 1'b1; stack_push = 1'b1; pc_value = 12'hEEE;
            end
         end else if (ph == 3'd0) begin
            pc_load = 1'b0; stack_push = 1'b0; stack_pop = 1'b0;
         end
         if (sp_rec && dut.sp_reg != sp_last) begin
            sp_hist.push_back(dut.sp_reg);
            sp_last = dut.sp_reg;
         end
      end
   end

   // Monitor: pops one expected instruction per instr_valid pulse
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (instr_valid) begin
            chk("valid_phase", 32'(phase), 32'd5);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_instr: got cmd=%h imm=%h, required none", command, immediate);
            end else begin
               e = exp_q.pop_front();
               chk("command", 32'(command), 32'(e.cmd));
               chk("immediate", 32'(immediate), 32'(e.imm));
               chk("operand", 32'(operand), 32'(e.opd));
               chk("two_byte", 32'(two_byte), 32'(e.two));
               chk("pc_at_x1", 32'(pc), 32'(e.pc));
               $display("instr pc=%03h cmd=%h imm=%h opd=%02h two=%b", pc, command, immediate, operand, two_byte);
            end
         end
      end
   end

   initial begin
      logic [1:0] sp_exp [8];
      sp_exp = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
      reset = 1'b1;
      clear_rom();
      // LDM 5; JUN 123; JUN 010; JMS 200; BBL; LDM 7; JUN (aborted by reset)
      rom[12'h000] = 8'hD5;
      rom[12'h001] = 8'h41; rom[12'h002] = 8'h23;
      rom[12'h123] = 8'h40; rom[12'h124] = 8'h10;
      rom[12'h010] = 8'h52; rom[12'h011] = 8'h00;
      rom[12'h200] = 8'hC0;
      rom[12'h012] = 8'hD7;
      rom[12'h013] = 8'h41; rom[12'h014] = 8'h23;
      push_exp(4'hD, 4'h5, 8'h00, 1'b0, 12'h001);
      push_exp(4'h4, 4'h1, 8'h23, 1'b1, 12'h003);
      push_exp(4'h4, 4'h0, 8'h10, 1'b1, 12'h125);
      push_exp(4'h5, 4'h2, 8'h00, 1'b1, 12'h012);
      push_exp(4'hC, 4'h0, 8'h00, 1'b0, 12'h201);
      push_exp(4'hD, 4'h7, 8'h00, 1'b0, 12'h013);
      addr_q = '{12'h000, 12'h001, 12'h002, 12'h123, 12'h124,
                 12'h010, 12'h011, 12'h200, 12'h012, 12'h013};
      repeat (3) @(negedge clk);
      chk("rst_phase", 32'(phase), 32'd0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_command", 32'(command), 32'd0);
      chk("rst_immediate", 32'(immediate), 32'd0);
      chk("rst_operand", 32'(operand), 32'd0);
      chk("rst_two_byte", 32'(two_byte), 32'd0);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_sync", 32'(sync), 32'd1);
      chk("rst_bus_drive", 32'(bus_drive), 32'd1);
      chk("rst_data_out", 32'(data_out), 32'd0);
      reset = 1'b0;
      wait_empty(400);

      // reset during X1 of the first byte of JUN at 0x013
      repeat (8) @(negedge clk);
      chk("pre_rst_phase", 32'(phase), 32'd5);
      chk("pre_rst_second", 32'(dut.second_reg), 32'd1);
      chk("part1_addr_left", 32'(addr_q.size()), 32'd0);
      reset = 1'b1;
      clear_rom();
      // four JMS, three BBL, JUN FFF, NOP at FFF
      rom[12'h000] = 8'h51; rom[12'h001] = 8'h00;
      rom[12'h100] = 8'h52; rom[12'h101] = 8'h00;
      rom[12'h200] = 8'h53; rom[12'h201] = 8'h00;
      rom[12'h300] = 8'h54; rom[12'h301] = 8'h00;
      rom[12'h400] = 8'hC0;
      rom[12'h302] = 8'hC0;
      rom[12'h202] = 8'hC0;
      rom[12'h102] = 8'h4F; rom[12'h103] = 8'hFF;
      rom[12'hFFF] = 8'h00;
      @(negedge clk);
      chk("mid_rst_phase", 32'(phase), 32'd0);
      chk("mid_rst_pc", 32'(pc), 32'd0);
      chk("mid_rst_command", 32'(command), 32'd0);
      chk("mid_rst_second", 32'(dut.second_reg), 32'd0);
      reset = 1'b0;
      sp_hist = '{2'd0};
      sp_last = 2'd0;
      sp_rec = 1'b1;
      push_exp(4'h5, 4'h1, 8'h00, 1'b1, 12'h002);
      push_exp(4'h5, 4'h2, 8'h00, 1'b1, 12'h102);
      push_exp(4'h5, 4'h3, 8'h00, 1'b1, 12'h202);
      push_exp(4'h5, 4'h4, 8'h00, 1'b1, 12'h302);
      push_exp(4'hC, 4'h0, 8'h00, 1'b0, 12'h401);
      push_exp(4'hC, 4'h0, 8'h00, 1'b0, 12'h303);
      push_exp(4'hC, 4'h0, 8'h00, 1'b0, 12'h203);
      push_exp(4'h4, 4'hF, 8'hFF, 1'b1, 12'h104);
      push_exp(4'h0, 4'h0, 8'hFF, 1'b0, 12'h000);
      addr_q = '{12'h000, 12'h001, 12'h100, 12'h101, 12'h200, 12'h201, 12'h300,
                 12'h301, 12'h400, 12'h302, 12'h202, 12'h102, 12'h103, 12'hFFF};
      wait_empty(400);
      sp_rec = 1'b0;
      chk("part2_addr_left", 32'(addr_q.size()), 32'd0);
      chk("sp_seq_len", 32'(sp_hist.size()), 32'd8);
      for (int i = 0; i < 8 && i < sp_hist.size(); i++) begin
         chk($sformatf("sp_seq[%0d]", i), 32'(sp_hist[i]), 32'(sp_exp[i]));
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
